// File: rtl/cheri_pkg.sv
// cheri_pkg - shared TS-map constants and the response-owner encoding.
package cheri_pkg;

  localparam int unsigned TSMapSizeDefault = 1024;
  localparam int unsigned StarveCntW       = 7;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_CORE    = 2'd1,
    OWN_REV_OK  = 2'd2,
    OWN_REV_ERR = 2'd3
  } rsp_owner_e;

endpackage

// File: rtl/ibexc_tsmap_arbiter.sv
// ibexc_tsmap_arbiter - single-port TS-map SRAM shared by the core read port
// (absolute priority) and the background revoker read/write port.
module ibexc_tsmap_arbiter
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize   = TSMapSizeDefault,
  parameter int unsigned StarveLimit = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_cs_i,
  input  logic [15:0] core_addr_i,
  output logic [31:0] core_rdata_o,

  input  logic        rev_req_i,
  input  logic        rev_we_i,
  input  logic [3:0]  rev_be_i,
  input  logic [15:0] rev_addr_i,
  input  logic [31:0] rev_wdata_i,
  output logic        rev_gnt_o,
  output logic        rev_rvalid_o,
  output logic        rev_err_o,
  output logic [31:0] rev_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [15:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,

  output logic        starve_o
);

  localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(StarveLimit);

  logic                  rev_gnt;
  logic                  rev_in_range;
  rsp_owner_e            owner_q, owner_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [StarveCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                  starve_q;

  assign rev_gnt      = rev_req_i & ~core_cs_i;
  assign rev_in_range = ({16'b0, rev_addr_i} < 32'(TSMapSize));
  assign rev_gnt_o    = rev_gnt;

  // An out-of-range grant never touches the SRAM; it only earns an error response.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = core_addr_i;
    ram_wdata_o = 32'h0;
    if (core_cs_i) begin
      ram_req_o = 1'b1;
      ram_be_o  = 4'hF;
    end else if (rev_gnt && rev_in_range) begin
      ram_req_o   = 1'b1;
      ram_we_o    = rev_we_i;
      ram_be_o    = rev_be_i;
      ram_addr_o  = rev_addr_i;
      ram_wdata_o = rev_wdata_i;
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    rsp_we_d = 1'b0;
    if (core_cs_i) begin
      owner_d = OWN_CORE;
    end else if (rev_gnt) begin
      owner_d  = rev_in_range ? OWN_REV_OK : OWN_REV_ERR;
      rsp_we_d = rev_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= OWN_NONE;
      rsp_we_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rsp_we_q <= rsp_we_d;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!rev_req_i || rev_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != StarveMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // The flag tracks the counter's next value so both change on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= (wait_cnt_d == StarveMax);
    end
  end

  assign starve_o     = starve_q;
  assign core_rdata_o = ram_rdata_i;
  assign rev_rvalid_o = (owner_q == OWN_REV_OK) || (owner_q == OWN_REV_ERR);
  assign rev_err_o    = (owner_q == OWN_REV_ERR);
  assign rev_rdata_o  = ((owner_q == OWN_REV_OK) && !rsp_we_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibexc_tsmap_arbiter.sv
// tb_ibexc_tsmap_arbiter - scoreboard bench for the TS-map arbiter with a behavioural SRAM.
module tb_ibexc_tsmap_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_cs = 1'b0;
  logic [15:0] core_addr = '0;
  logic [31:0] core_rdata;
  logic        rev_req = 1'b0;
  logic        rev_we = 1'b0;
  logic [3:0]  rev_be = '0;
  logic [15:0] rev_addr = '0;
  logic [31:0] rev_wdata = '0;
  logic        rev_gnt, rev_rvalid, rev_err;
  logic [31:0] rev_rdata;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        starve;

  int total = 0;
  int bad = 0;

  logic [31:0] sram  [0:1023];
  logic [31:0] model [0:1023];
  logic        mem_load = 1'b0;
  logic        core_pend = 1'b0;
  rsp_t        rsp_q[$];
  logic [31:0] core_q[$];

  always #5 clk = ~clk;

  ibexc_tsmap_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_cs_i(core_cs), .core_addr_i(core_addr), .core_rdata_o(core_rdata),
    .rev_req_i(rev_req), .rev_we_i(rev_we), .rev_be_i(rev_be), .rev_addr_i(rev_addr),
    .rev_wdata_i(rev_wdata), .rev_gnt_o(rev_gnt), .rev_rvalid_o(rev_rvalid),
    .rev_err_o(rev_err), .rev_rdata_o(rev_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .starve_o(starve)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h010) return 32'hA5A5_0001;
    if (i == 'h3FF) return 32'h0;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
    end else if (ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) sram[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= sram[ram_addr[9:0]];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_pend <= 1'b0;
    else        core_pend <= core_cs;
  end

  always @(negedge clk) begin
    if (core_pend) begin
      total++;
      if (core_q.size() == 0) begin
        bad++;
        $display("FAIL core_rsp_unexpected: got %h, required no core response", core_rdata);
      end else begin
        automatic logic [31:0] exp = core_q.pop_front();
        if (core_rdata !== exp) begin
          bad++;
          $display("FAIL core_rdata: got %h, required %h", core_rdata, exp);
        end
      end
    end
    if (rev_rvalid !== 1'b0) begin
      total++;
      if (rsp_q.size() == 0) begin
        bad++;
        $display("FAIL rev_rsp_unexpected: rvalid=%b, required 0", rev_rvalid);
      end else begin
        automatic rsp_t exp = rsp_q.pop_front();
        if (rev_err !== exp.err || rev_rdata !== exp.rdata) begin
          bad++;
          $display("FAIL rev_rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                   rev_err, rev_rdata, exp.err, exp.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus and records what the DUT must answer with.
  task automatic step(input logic cs, input logic [15:0] caddr, input logic req,
                      input logic we, input logic [3:0] be, input logic [15:0] raddr,
                      input logic [31:0] wd);
    rsp_t r;
    core_cs = cs; core_addr = caddr;
    rev_req = req; rev_we = we; rev_be = be; rev_addr = raddr; rev_wdata = wd;
    if (rst_n && cs) core_q.push_back(model[caddr[9:0]]);
    if (rst_n && req && !cs) begin
      r.err = (raddr >= 16'd1024);
      r.rdata = (r.err || we) ? 32'h0 : model[raddr[9:0]];
      if (!r.err && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) model[raddr[9:0]][8*b +: 8] = wd[8*b +: 8];
      rsp_q.push_back(r);
    end
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (rev_rvalid !== 1'b0 || rev_err !== 1'b0 || starve !== 1'b0 || rev_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rvalid=%b err=%b starve=%b rdata=%h, required 0 0 0 0",
               rev_rvalid, rev_err, starve, rev_rdata);
    end
    total++;
    if (rev_gnt !== 1'b0 || ram_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_port: got gnt=%b ram_req=%b, required 0 0", rev_gnt, ram_req);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_core_read();
    step(1'b1, 16'h0010, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    @(negedge clk);
    total++;
    if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0010 || rev_gnt !== 1'b0) begin
      bad++;
      $display("FAIL core_port_drive: got req=%b we=%b addr=%h gnt=%b, required 1 0 0010 0",
               ram_req, ram_we, ram_addr, rev_gnt);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (core_rdata !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL core_read_0x010: got %h, required a5a50001", core_rdata);
    end
    tick();
  endtask

  task automatic test_collision();
    step(1'b1, 16'h0020, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0);
    @(negedge clk);
    total++;
    if (rev_gnt !== 1'b0 || ram_addr !== 16'h0020 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL collision_core_wins: got gnt=%b addr=%h we=%b, required 0 0020 0",
               rev_gnt, ram_addr, ram_we);
    end
    tick();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0);
    @(negedge clk);
    total++;
    if (rev_gnt !== 1'b1 || ram_req !== 1'b1 || ram_addr !== 16'h0020) begin
      bad++;
      $display("FAIL collision_rev_later: got gnt=%b req=%b addr=%h, required 1 1 0020",
               rev_gnt, ram_req, ram_addr);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (rev_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL collision_rvalid: got %b, required 1", rev_rvalid);
    end
    tick();
  endtask

  task automatic test_write_read();
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'b0011, 16'h03FF, 32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'b0011 || ram_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rev_write_drive: got req=%b we=%b be=%b wdata=%h, required 1 1 0011 deadbeef",
               ram_req, ram_we, ram_be, ram_wdata);
    end
    tick();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h03FF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    total++;
    if (rev_rdata !== 32'h0000_BEEF || rev_err !== 1'b0) begin
      bad++;
      $display("FAIL write_read_0x3ff: got rdata=%h err=%b, required 0000beef 0", rev_rdata, rev_err);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0400, 32'h0);
    @(negedge clk);
    total++;
    if (rev_gnt !== 1'b1 || ram_req !== 1'b0) begin
      bad++;
      $display("FAIL oor_grant: got gnt=%b ram_req=%b, required 1 0", rev_gnt, ram_req);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (rev_rvalid !== 1'b1 || rev_err !== 1'b1 || rev_rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_rsp: got rvalid=%b err=%b rdata=%h, required 1 1 0", rev_rvalid, rev_err, rev_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0100, 32'h1234_5678);
    tick();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0);
    tick();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'hFFFF, 32'h0);
    tick();
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0055, 32'h0);
    tick();
    idle();
    tick();
    total++;
    if (rsp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drained: %0d responses outstanding, required 0", rsp_q.size());
    end
  endtask

  task automatic test_starvation();
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 16'(k * 7), 1'b1, 1'b0, 4'h0, 16'h0040, 32'h0);
      @(negedge clk);
      total++;
      if (starve !== (k >= 65)) begin
        bad++;
        $display("FAIL starve_cycle_%0d: got %b, required %b", k, starve, (k >= 65));
      end
      tick();
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0040, 32'h0);
    @(negedge clk);
    total++;
    if (rev_gnt !== 1'b1 || starve !== 1'b1) begin
      bad++;
      $display("FAIL starve_grant_cycle: got gnt=%b starve=%b, required 1 1", rev_gnt, starve);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (starve !== 1'b0) begin
      bad++;
      $display("FAIL starve_clear: got %b, required 0", starve);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0030, 32'h0);
    @(negedge clk);
    total++;
    if (rev_gnt !== 1'b1 || ram_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_comb_path: got gnt=%b ram_req=%b, required 1 1", rev_gnt, ram_req);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (rev_rvalid !== 1'b0 || rev_err !== 1'b0 || starve !== 1'b0 || rev_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got rvalid=%b err=%b starve=%b rdata=%h, required 0 0 0 0",
               rev_rvalid, rev_err, starve, rev_rdata);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (rsp_q.size() != 0 || core_q.size() != 0) begin
      bad++;
      $display("FAIL final_drained: rev=%0d core=%0d outstanding, required 0 0", rsp_q.size(), core_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = init_word(i);
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    test_reset();
    test_core_read();
    test_collision();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibexc_tsmap_arbiter.md
IBEXC_TSMAP_ARBITER -- requirements
Module: ibexc_tsmap_arbiter

Shares the single-port TS-map (revocation bitmap) SRAM between the core's fixed-latency read port and a background revoker read/write port.

Interface
REQ-001 The block SHALL have parameter TSMapSize, default 1024, meaning the SRAM depth in 32-bit words.
REQ-002 The block SHALL have parameter StarveLimit, default 64, meaning the number of wait cycles before the starvation flag.
REQ-003 Port clk_i  input  1  is the single clock.
REQ-004 Port rst_ni  input  1  is the asynchronous active-low reset.
REQ-005 Port core_cs_i  input  1  is the core TS-map read strobe.
REQ-006 Port core_addr_i  input  16  is the core word address.
REQ-007 Port core_rdata_o  output  32  is the core read data.
REQ-008 Port rev_req_i  input  1  is the revoker request.
REQ-009 Port rev_we_i  input  1  is the revoker write enable.
REQ-010 Port rev_be_i  input  4  is the revoker byte enables.
REQ-011 Port rev_addr_i  input  16  is the revoker word address.
REQ-012 Port rev_wdata_i  input  32  is the revoker write data.
REQ-013 Port rev_gnt_o  output  1  is the revoker grant.
REQ-014 Port rev_rvalid_o  output  1  is the revoker response valid.
REQ-015 Port rev_err_o  output  1  is the revoker response error.
REQ-016 Port rev_rdata_o  output  32  is the revoker read data.
REQ-017 Port ram_req_o, ram_we_o, ram_be_o[3:0], ram_addr_o[15:0], ram_wdata_o[31:0]  output  drive the SRAM port.
REQ-018 Port ram_rdata_i  input  32  is the SRAM read data, valid one cycle after ram_req_o.
REQ-019 Port starve_o  output  1  is the revoker starvation flag.

Function
REQ-020 The core port SHALL have absolute priority, because the core cannot stall: core_cs_i=1 SHALL drive ram_req_o=1, ram_we_o=0, ram_addr_o=core_addr_i combinationally in the same cycle.
REQ-021 core_rdata_o SHALL equal ram_rdata_i in the cycle after a core access; its value in other cycles is don't-care.
REQ-022 rev_gnt_o SHALL equal rev_req_i & ~core_cs_i, combinationally.
REQ-023 For an in-range grant (rev_addr_i < TSMapSize), the block SHALL drive ram_req_o=1 with the revoker we/be/addr/wdata in the grant cycle.
REQ-024 For an out-of-range grant, the block SHALL NOT assert ram_req_o.
REQ-025 Every grant SHALL produce exactly one rev_rvalid_o pulse in the following cycle, with rev_err_o=1 if and only if the grant was out-of-range.
REQ-026 rev_rdata_o SHALL equal ram_rdata_i for an in-range read response, and SHALL be 0 for writes and errored responses.
REQ-027 The response owner (none/core/revoker-ok/revoker-err) SHALL be held in a 2-bit registered state updated every cycle; the reset state is none.
REQ-028 The revoker SHALL hold rev_req_i and its payload stable until granted; the block SHALL NOT buffer more than one outstanding revoker transaction.
REQ-029 A 7-bit wait counter SHALL increment each cycle with rev_req_i & ~rev_gnt_o, clear on grant or when rev_req_i=0, and saturate at StarveLimit.
REQ-030 starve_o SHALL be registered, and SHALL equal 1 while the counter equals StarveLimit.
REQ-031 Back-to-back grants in consecutive cycles SHALL each receive their own response in the next cycle.
REQ-032 Core and revoker requesting the same address in the same cycle SHALL serve the core; the revoker is granted in a later cycle.

Reset
REQ-033 During reset, rev_rvalid_o=0, rev_err_o=0, starve_o=0, the counter=0 and the owner=none.
REQ-034 A response pending when reset asserts SHALL be discarded; no rev_rvalid_o SHALL be issued after reset deasserts.
REQ-035 ram_req_o SHALL follow the combinational rules above during reset; the SRAM content is not reset.

Structure
REQ-036 The TSMapSize default and the 2-bit owner enum SHALL live in cheri_pkg.
REQ-037 No sub-module SHALL be used; the block is a single flat module.

Verification
REQ-038 Core read only: core_cs_i=1, addr=0x010 with RAM word 0xA5A5_0001 -> core_rdata_o=0xA5A5_0001 in the next cycle, rev_gnt_o=0.
REQ-039 Collision: core_cs_i and rev_req_i both asserted at addr 0x020 -> cycle N core is served; cycle N+1 rev_gnt_o=1; cycle N+2 rev_rvalid_o=1 with the RAM data.
REQ-040 Revoker write then read: write 0xDEAD_BEEF with be=4'b0011 at 0x3FF, then read 0x3FF -> rdata=0x0000_BEEF (prior word 0), err=0.
REQ-041 Out of range: revoker read at 0x0400 (TSMapSize=1024) -> gnt=1, ram_req_o=0, next cycle rvalid=1, err=1, rdata=0.
REQ-042 Starvation: core_cs_i held for 70 cycles with rev_req_i=1 -> starve_o=1 from cycle 65; it clears the cycle after the grant.
REQ-043 Reset mid-operation: rst_ni low in the grant cycle -> no rvalid pulse afterwards, and all outputs at their reset values.
